// File: rtl/flr_req_issuer_pkg.sv
// Shared types and default widths for the FLR request issuer.
package flr_req_issuer_pkg;

  localparam int unsigned DEF_PF_W           = 3;
  localparam int unsigned DEF_VF_W           = 11;
  localparam int unsigned DEF_FIFO_DEPTH     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_CNT_W          = 16;

  // Function identifier carried on every interface: {vf_active, pf, vf}.
  typedef struct packed {
    logic                vf_active;
    logic [DEF_PF_W-1:0] pf_num;
    logic [DEF_VF_W-1:0] vf_num;
  } t_flr_func;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    DONE
  } t_issuer_state;

  function automatic int unsigned func_width(input int unsigned pf_w, input int unsigned vf_w);
    return 1 + pf_w + vf_w;
  endfunction

endpackage

// File: rtl/flr_evt_fifo.sv
// Register FIFO holding pending FLR events.
// With FLR_REQ_ISSUER_DUP_FILTER_EN defined it also reports, per entry, whether an occupied
// slot equals the compare input.
module flr_evt_fifo
  import flr_req_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  parameter type         T     = t_flr_func
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  T                 wdata,
  input  logic             pop,
  output T                 rdata,
  output logic             full,
  output logic             empty
`ifdef FLR_REQ_ISSUER_DUP_FILTER_EN
  ,
  input  T                 cmp,
  output logic [DEPTH-1:0] match
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem_q [DEPTH];
  // Extra MSB on each pointer separates full (MSBs differ) from empty (MSBs equal).
  logic [PTR_W:0]   wr_q;
  logic [PTR_W:0]   rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign rdata   = mem_q[rd_q[PTR_W-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; wraps naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Entry storage; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= wdata;
  end

`ifdef FLR_REQ_ISSUER_DUP_FILTER_EN
  logic [PTR_W:0] count;
  assign count = wr_q - rd_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    logic [PTR_W-1:0] offs;
    // Slot g is occupied when its distance from the read pointer is below the fill level.
    assign offs     = PTR_W'(g) - rd_q[PTR_W-1:0];
    assign match[g] = ({1'b0, offs} < count) && (mem_q[g] == cmp);
  end
`endif

endmodule

// File: rtl/flr_req_issuer.sv
// FLR request issuer: queues PF/VF FLR events, issues them one at a time to the port gasket
// reset manager and reports completion (or timeout) back to the PCIe SS sideband.
// Optional macro FLR_REQ_ISSUER_DUP_FILTER_EN merges events already queued or in flight.
module flr_req_issuer
  import flr_req_issuer_pkg::*;
#(
  parameter int unsigned PF_W           = DEF_PF_W,
  parameter int unsigned VF_W           = DEF_VF_W,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_evt_valid,
  output logic                 o_evt_ready,
  input  logic [PF_W+VF_W:0]   i_evt_func,
  output logic                 o_flr_req_tvalid,
  output logic [PF_W+VF_W:0]   o_flr_req_tdata,
  input  logic                 i_flr_rsp_tvalid,
  input  logic [PF_W+VF_W:0]   i_flr_rsp_tdata,
  output logic                 o_done_valid,
  output logic [PF_W+VF_W:0]   o_done_func,
  output logic                 o_done_timeout,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_timeout_cnt,
  output logic [CNT_W-1:0]     o_stray_rsp_cnt
);

  localparam int unsigned FUNC_W = func_width(PF_W, VF_W);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYCLES);

  typedef logic [FUNC_W-1:0] func_t;

  t_issuer_state      state_q, state_d;
  func_t              cur_func_q;
  logic [TMR_W-1:0]   timer_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   timeout_cnt_q;
  logic [CNT_W-1:0]   stray_cnt_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  func_t              fifo_rdata;
  logic               evt_accept;
  logic               rsp_match;
  logic               rsp_stray;
  logic               timer_expired;
  logic               clr_timer;
  logic               inc_timer;
  logic               to_we;
  logic               to_val;
  logic               to_inc;

  // Ready reflects only the registered fill state, never a same-cycle pop.
  assign o_evt_ready   = rst_n & ~fifo_full;
  assign evt_accept    = i_evt_valid && o_evt_ready;
  assign rsp_match     = i_flr_rsp_tvalid && (i_flr_rsp_tdata == cur_func_q);
  assign rsp_stray     = i_flr_rsp_tvalid && !((state_q == WAIT_RSP) && rsp_match);
  assign timer_expired = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

`ifdef FLR_REQ_ISSUER_DUP_FILTER_EN
  logic [FIFO_DEPTH-1:0] fifo_match;
  logic                  dup_hit;
  // A function already queued, or currently being requested/awaited, is not queued again.
  assign dup_hit   = (|fifo_match) ||
                     (((state_q == ISSUE) || (state_q == WAIT_RSP)) && (i_evt_func == cur_func_q));
  assign fifo_push = evt_accept && !dup_hit;
`else
  assign fifo_push = evt_accept;
`endif

  flr_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (func_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (i_evt_func),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
`ifdef FLR_REQ_ISSUER_DUP_FILTER_EN
    ,
    .cmp   (i_evt_func),
    .match (fifo_match)
`endif
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and pulse outputs.
  always_comb begin
    state_d          = state_q;
    fifo_pop         = 1'b0;
    clr_timer        = 1'b0;
    inc_timer        = 1'b0;
    to_we            = 1'b0;
    to_val           = 1'b0;
    to_inc           = 1'b0;
    o_flr_req_tvalid = 1'b0;
    o_done_valid     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        o_flr_req_tvalid = 1'b1;
        clr_timer        = 1'b1;
        state_d          = WAIT_RSP;
      end
      WAIT_RSP: begin
        inc_timer = 1'b1;
        // A match on the expiry cycle wins over the timeout.
        if (rsp_match) begin
          to_we   = 1'b1;
          to_val  = 1'b0;
          state_d = DONE;
        end else if (timer_expired) begin
          to_we   = 1'b1;
          to_val  = 1'b1;
          to_inc  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        o_done_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Current function, response timer and completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_func_q <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (fifo_pop)       cur_func_q <= fifo_rdata;
      if (clr_timer)      timer_q    <= '0;
      else if (inc_timer) timer_q    <= timer_q + 1'b1;
      if (to_we)          timeout_q  <= to_val;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt_q <= '0;
      stray_cnt_q   <= '0;
    end else begin
      if (to_inc && (timeout_cnt_q != '1))  timeout_cnt_q <= timeout_cnt_q + 1'b1;
      if (rsp_stray && (stray_cnt_q != '1)) stray_cnt_q   <= stray_cnt_q + 1'b1;
    end
  end

  assign o_flr_req_tdata = o_flr_req_tvalid ? cur_func_q : '0;
  assign o_done_func     = o_done_valid ? cur_func_q : '0;
  assign o_done_timeout  = o_done_valid & timeout_q;
  assign o_busy          = (state_q != IDLE) || !fifo_empty;
  assign o_timeout_cnt   = timeout_cnt_q;
  assign o_stray_rsp_cnt = stray_cnt_q;

endmodule
